// File: rtl/parity_frame_tx.sv
// parity_frame_tx: serialises a DATA_W-bit word plus its even-parity bit as an
// idle-high frame (start, data LSB-first, parity, stop), each bit held for
// CLKS_PER_BIT clocks. Words arrive through a valid/ready handshake.
//
// Optional feature, macro PARITY_CHECK_EN:
//   defined   - the parity bit is recomputed from data_in on accept and that
//               bit is sent; parity_err pulses if parity_in disagreed.
//   undefined - parity_in is sent unchanged and parity_err is tied low.
module parity_frame_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              parity_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done,
    output logic              parity_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    // Last clock of a bit period and index of the final data bit.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

`ifdef PARITY_CHECK_EN
    // Even parity of a word: XOR reduction.
    function automatic logic even_parity(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction
`endif

    state_t            state_q,  state_d;
    logic [DATA_W-1:0] shift_q,  shift_d;
    logic              par_q,    par_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [IDX_W-1:0]  idx_q,    idx_d;
    logic              tx_q,     tx_d;
    logic              ready_q,  ready_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
`ifdef PARITY_CHECK_EN
    logic              perr_q,   perr_d;
`endif

    logic              bit_end_s;
    logic [DATA_W-1:0] shift_nxt_s;

    // Bit period ends on the last clock of the per-bit counter.
    assign bit_end_s   = (cnt_q == CNT_LAST);
    // Shift register contents once the current data bit is consumed.
    assign shift_nxt_s = shift_q >> 1'b1;

    // Next-state and next-output logic; outputs are computed for the state
    // being entered so that the registered outputs line up with the state.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        par_d   = par_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef PARITY_CHECK_EN
        perr_d  = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
                cnt_d   = '0;
                idx_d   = '0;
                if (valid_in && ready_q) begin
                    shift_d = data_in;
`ifdef PARITY_CHECK_EN
                    par_d   = even_parity(data_in);
                    perr_d  = (parity_in != even_parity(data_in));
`else
                    par_d   = parity_in;
`endif
                    state_d = S_START;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_START: begin
                if (bit_end_s) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            S_DATA: begin
                if (bit_end_s) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_PARITY;
                        tx_d    = par_q;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        shift_d = shift_nxt_s;
                        tx_d    = shift_nxt_s[0];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_PARITY: begin
                if (bit_end_s) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            S_STOP: begin
                if (bit_end_s) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drives the line idle-high at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PARITY_CHECK_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign tx_out     = tx_q;
    assign ready_out  = ready_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
`ifdef PARITY_CHECK_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_parity_frame_tx.sv
// Testbench for parity_frame_tx (DATA_W=4, CLKS_PER_BIT=4). A frame-level
// model predicts every output on every cycle; literal frame patterns pin it.
module tb_parity_frame_tx;

    localparam int DW  = 4;
    localparam int CPB = 4;
    localparam int NB  = DW + 3;
    localparam int N   = NB * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          parity_in = 1'b0;
    logic          valid_in = 1'b0;
    logic          ready_out, tx_out, busy, frame_done, parity_err;

    int n_cmp = 0;
    int n_err = 0;

    parity_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .parity_in  (parity_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .tx_out     (tx_out),
        .busy       (busy),
        .frame_done (frame_done),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int      cyc = 0;
    int      acc = -1;          // clock edge of the last accepted word
    logic    fbits [0:NB-1];    // levels of that frame, in send order
    bit      mism = 0;

    initial forever begin : model
        int ones;
        @(posedge clk or posedge rst);
        if (rst) begin
            acc  = -1;
            mism = 0;
        end else begin
            cyc++;
            if ((acc < 0 || cyc - 1 >= acc + N) && valid_in) begin
                ones = 0;
                for (int i = 0; i < DW; i++) ones += int'(data_in[i]);
                fbits[0] = 1'b0;
                for (int i = 0; i < DW; i++) fbits[1 + i] = data_in[i];
`ifdef PARITY_CHECK_EN
                fbits[DW + 1] = (ones % 2 == 1);
`else
                fbits[DW + 1] = parity_in;
`endif
                fbits[DW + 2] = 1'b1;
                mism = ((ones % 2 == 1) != parity_in);
                acc  = cyc;
            end
        end
    end

    // Compare every output against the model each cycle out of reset.
    initial forever begin : compare
        logic e_tx, e_busy, e_rdy, e_done, e_perr;
        @(negedge clk);
        if (!rst) begin
            if (acc >= 0 && cyc - acc < N) begin
                e_tx = fbits[(cyc - acc) / CPB]; e_busy = 1'b1; e_rdy = 1'b0; e_done = 1'b0;
            end else begin
                e_tx = 1'b1; e_busy = 1'b0; e_rdy = 1'b1;
                e_done = (acc >= 0 && cyc == acc + N);
            end
`ifdef PARITY_CHECK_EN
            e_perr = (acc >= 0 && cyc == acc && mism);
`else
            e_perr = 1'b0;
`endif
            check("model_tx", tx_out, e_tx);
            check("model_busy", busy, e_busy);
            check("model_ready", ready_out, e_rdy);
            check("model_done", frame_done, e_done);
            check("model_perr", parity_err, e_perr);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic log_tx [0:63];
    logic log_dn [0:63];
    logic log_pe [0:63];

    // Present a word at a falling edge, keep valid for 'hold' cycles, and
    // record ncap samples starting in the cycle after the first accept edge.
    task automatic send_capture(input logic [DW-1:0] d, input logic p, input int hold, input int ncap);
        @(negedge clk);
        data_in = d; parity_in = p; valid_in = 1'b1;
        for (int i = 0; i < ncap; i++) begin
            @(negedge clk);
            log_tx[i] = tx_out; log_dn[i] = frame_done; log_pe[i] = parity_err;
            if (i + 1 == hold) valid_in = 1'b0;
        end
        valid_in = 1'b0;
    endtask

    // Compare a captured frame with seven hand-written levels (MSB sent first).
    task automatic check_frame(input string name, input logic [6:0] lv, input int start);
        int bad;
        bad = 0;
        for (int j = 0; j < N; j++)
            if (log_tx[start + j] !== lv[6 - j / CPB]) bad++;
        check(name, bad, 0);
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle_timeout", (i >= 200) ? 1 : 0, 0);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin : stim
        int cnt;
        #1 rst = 1'b1;
        #1;
        check("rst_tx", tx_out, 1); check("rst_ready", ready_out, 1);
        check("rst_busy", busy, 0); check("rst_done", frame_done, 0);
        check("rst_perr", parity_err, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: idle line, no valid
        repeat (20) begin
            @(negedge clk);
            check("idle_tx", tx_out, 1); check("idle_ready", ready_out, 1);
            check("idle_busy", busy, 0); check("idle_done", frame_done, 0);
        end

        // 2: single 0011/0 frame
        send_capture(4'b0011, 1'b0, 1, 29);
        check_frame("s2_frame", 7'b0110001, 0);
        check("s2_done_cyc29", log_dn[28], 1);
        cnt = 0;
        for (int i = 0; i < 29; i++) cnt += int'(log_dn[i]);
        check("s2_done_count", cnt, 1);
        wait_idle();

        // 3: back-to-back 0111/1 frames with valid held
        send_capture(4'b0111, 1'b1, 58, 58);
        check_frame("s3_frame1", 7'b0111011, 0);
        check("s3_gap_idle", log_tx[28], 1);
        check_frame("s3_frame2", 7'b0111011, 29);
        cnt = 0;
        for (int i = 0; i < 58; i++) cnt += int'(log_dn[i]);
        check("s3_done_count", cnt, 2);
        wait_idle();

        // 4: valid held with data toggling randomly during frames
        @(negedge clk);
        valid_in = 1'b1;
        repeat (80) begin
            @(negedge clk);
            data_in = DW'($urandom); parity_in = 1'($urandom);
        end
        valid_in = 1'b0;
        wait_idle();
        for (int k = 0; k < 6; k++) begin
            send_capture(DW'($urandom), 1'($urandom), 1, 1);
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        wait_idle();

        // 5: reset during the DATA state of a 1111/0 frame
        send_capture(4'b1111, 1'b0, 1, 10);
        #1 rst = 1'b1;
        #1;
        check("s5_rst_tx", tx_out, 1); check("s5_rst_ready", ready_out, 1);
        check("s5_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            cnt += int'(frame_done);
        end
        check("s5_no_done", cnt, 0);
        send_capture(4'b0001, 1'b1, 1, 29);
        check_frame("s5_frame_after", 7'b0100011, 0);
        check("s5_done", log_dn[28], 1);
        wait_idle();

        // 6: 0001 with wrong parity 0
        send_capture(4'b0001, 1'b0, 1, 29);
`ifdef PARITY_CHECK_EN
        check_frame("s6_frame", 7'b0100011, 0);
        check("s6_perr_pulse", log_pe[0], 1);
        cnt = 0;
        for (int i = 0; i < 29; i++) cnt += int'(log_pe[i]);
        check("s6_perr_count", cnt, 1);
`else
        check_frame("s6_frame", 7'b0100001, 0);
        cnt = 0;
        for (int i = 0; i < 29; i++) cnt += int'(log_pe[i]);
        check("s6_perr_count", cnt, 0);
`endif
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
